decode_stage: RTL and testbench

- Instruction-decode stage of the 5-stage 16-bit pipelined CPU.
- Sits between fetch_b (synchronous instruction memory output plus PC) and execute.
- Holds the 16x16 register file, which is written by writeback.
- Reads operands, detects load-use hazards and raises stall.
- Tags each issued instruction with one-/two-cycle producer-dependency flags that execute uses for forwarding.

---
 rtl/decode_stage.sv | 154 +++++++++++++++
 tb/tb_decode_stage.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Instruction-decode stage: register file, operand read with write-through bypass,
// load-use stall with a one-entry skid register, and producer-dependency tagging.
module decode_stage #(
  parameter logic [3:0] LOAD_OP   = 4'b1000,
  parameter logic [3:0] STORE_OP  = 4'b1001,
  parameter logic [2:0] BRANCH_HI = 3'b101,
  parameter logic [3:0] HALT_OP   = 4'b1111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [15:0] instr_in,
  input  logic        bubble_in,
  input  logic [15:0] pc_in,
  input  logic        reg_we,
  input  logic [3:0]  reg_tgt,
  input  logic [15:0] reg_wdata,
  output logic [15:0] op1_out,
  output logic [15:0] op2_out,
  output logic [15:0] pc_out,
  output logic [15:0] instr_out,
  output logic        bubble_out,
  output logic        was_pair,
  output logic        was_was_pair,
  output logic        stall
);

  typedef struct packed {
    logic        vld;
    logic [15:0] instr;
    logic [15:0] pc;
  } slot_t;

  typedef struct packed {
    logic       wr;
    logic [3:0] rt;
  } hist_t;

  // Store and branch carry their second source in the rt field.
  function automatic logic rt_is_src(input logic [15:0] i);
    return (i[15:12] == STORE_OP) || (i[15:13] == BRANCH_HI);
  endfunction

  function automatic logic [3:0] rs2_of(input logic [15:0] i);
    return rt_is_src(i) ? i[3:0] : i[11:8];
  endfunction

  function automatic logic writes(input logic vld, input logic [15:0] i);
    return vld && !rt_is_src(i) && (i[15:12] != HALT_OP) && (i[3:0] != 4'd0);
  endfunction

  function automatic logic dep(input hist_t hs, input logic [3:0] a, input logic [3:0] b);
    return hs.wr && ((hs.rt == a) || (hs.rt == b));
  endfunction

  logic [15:0][15:0] rf;
  slot_t             skid;
  logic              use_skid;
  slot_t             h;
  logic [3:0]        h_rs1, h_rs2;
  logic [15:0]       rd1, rd2;
  hist_t             hist1, hist2;
  logic              out_load;

  // Register file; R0 is never written so it always reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf <= '0;
    end else if (reg_we && (reg_tgt != 4'd0)) begin
      rf[reg_tgt] <= reg_wdata;
    end
  end

  always_comb begin
    h.vld   = ~bubble_in;
    h.instr = instr_in;
    h.pc    = pc_in;
    if (use_skid) h = skid;
  end

  assign h_rs1 = h.instr[7:4];
  assign h_rs2 = rs2_of(h.instr);

  always_comb begin
    rd1 = rf[h_rs1];
    if (reg_we && (reg_tgt == h_rs1)) rd1 = reg_wdata;
    if (h_rs1 == 4'd0) rd1 = '0;
    rd2 = rf[h_rs2];
    if (reg_we && (reg_tgt == h_rs2)) rd2 = reg_wdata;
    if (h_rs2 == 4'd0) rd2 = '0;
  end

  assign out_load = !bubble_out && (instr_out[15:12] == LOAD_OP) && (instr_out[3:0] != 4'd0);
  assign stall    = h.vld && out_load &&
                    ((instr_out[3:0] == h_rs1) || (instr_out[3:0] == h_rs2));

  // Skid holds the stalled instruction, since fetch may move its output while held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid     <= '0;
      use_skid <= 1'b0;
    end else if (flush) begin
      skid     <= '0;
      use_skid <= 1'b0;
    end else begin
      skid     <= h;
      use_skid <= stall;
    end
  end

  // Issue register plus the two-deep history of issued slots.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op1_out      <= '0;
      op2_out      <= '0;
      pc_out       <= '0;
      instr_out    <= '0;
      bubble_out   <= 1'b1;
      was_pair     <= 1'b0;
      was_was_pair <= 1'b0;
      hist1        <= '0;
      hist2        <= '0;
    end else if (flush) begin
      op1_out      <= '0;
      op2_out      <= '0;
      pc_out       <= '0;
      instr_out    <= '0;
      bubble_out   <= 1'b1;
      was_pair     <= 1'b0;
      was_was_pair <= 1'b0;
      hist1        <= '0;
      hist2        <= '0;
    end else if (stall) begin
      instr_out    <= '0;
      bubble_out   <= 1'b1;
      was_pair     <= 1'b0;
      was_was_pair <= 1'b0;
      hist1        <= '0;
      hist2        <= hist1;
    end else begin
      op1_out      <= rd1;
      op2_out      <= rd2;
      pc_out       <= h.pc;
      instr_out    <= h.instr;
      bubble_out   <= ~h.vld;
      was_pair     <= h.vld && dep(hist1, h_rs1, h_rs2);
      was_was_pair <= h.vld && dep(hist2, h_rs1, h_rs2);
      hist1.wr     <= writes(h.vld, h.instr);
      hist1.rt     <= h.instr[3:0];
      hist2        <= hist1;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: table of per-cycle stimulus with expected issue results,
// checked through a scoreboard queue one cycle later, plus a mid-run reset sequence.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst, flush, bubble_in, reg_we;
  logic [15:0] instr_in, pc_in, reg_wdata;
  logic [3:0]  reg_tgt;
  logic [15:0] op1_out, op2_out, pc_out, instr_out;
  logic        bubble_out, was_pair, was_was_pair, stall;

  decode_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .instr_in(instr_in), .bubble_in(bubble_in),
    .pc_in(pc_in), .reg_we(reg_we), .reg_tgt(reg_tgt), .reg_wdata(reg_wdata),
    .op1_out(op1_out), .op2_out(op2_out), .pc_out(pc_out), .instr_out(instr_out),
    .bubble_out(bubble_out), .was_pair(was_pair), .was_was_pair(was_was_pair), .stall(stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [1:0]  chk;  // 2: check all data, 1: instr only, 0: flags only
    logic        eb;
    logic [15:0] ei, e1, e2, ep;
    logic        wp, wwp;
  } exp_t;

  typedef struct {
    logic [15:0] instr;
    logic        bub;
    logic [15:0] pc;
    logic        we;
    logic [3:0]  tgt;
    logic [15:0] wd;
    logic        fl;
    logic        st;
    exp_t        e;
  } vec_t;

  vec_t vecs[18];
  exp_t sb[$];
  int   pass_cnt = 0;
  int   total    = 0;

  function automatic vec_t mk(input logic [15:0] instr, input logic bub, input logic [15:0] pc,
                              input logic we, input logic [3:0] tgt, input logic [15:0] wd,
                              input logic fl, input logic st, input logic [1:0] chk,
                              input logic eb, input logic [15:0] ei, input logic [15:0] e1,
                              input logic [15:0] e2, input logic [15:0] ep,
                              input logic wp, input logic wwp);
    vec_t v;
    v.instr = instr; v.bub = bub; v.pc = pc; v.we = we; v.tgt = tgt; v.wd = wd;
    v.fl = fl; v.st = st;
    v.e.idx = 0; v.e.chk = chk; v.e.eb = eb; v.e.ei = ei; v.e.e1 = e1; v.e.e2 = e2;
    v.e.ep = ep; v.e.wp = wp; v.e.wwp = wwp;
    return v;
  endfunction

  task automatic chk16(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
  endtask

  task automatic compare(input exp_t e);
    chk16("bubble_out", e.idx, {15'd0, bubble_out}, {15'd0, e.eb});
    chk16("was_pair", e.idx, {15'd0, was_pair}, {15'd0, e.wp});
    chk16("was_was_pair", e.idx, {15'd0, was_was_pair}, {15'd0, e.wwp});
    if (e.chk != 2'd0) chk16("instr_out", e.idx, instr_out, e.ei);
    if (e.chk == 2'd2) begin
      chk16("op1_out", e.idx, op1_out, e.e1);
      chk16("op2_out", e.idx, op2_out, e.e2);
      chk16("pc_out", e.idx, pc_out, e.ep);
    end
  endtask

  task automatic pop_compare();
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      $display("FAIL scoreboard: got empty queue expected an entry");
    end else begin
      pass_cnt++;
      e = sb.pop_front();
      compare(e);
    end
  endtask

  initial begin
    exp_t e;
    rst = 1'b1; flush = 1'b0; bubble_in = 1'b1; instr_in = '0; pc_in = '0;
    reg_we = 1'b0; reg_tgt = '0; reg_wdata = '0;

    //             instr     bub pc        we tgt wdata    fl st chk eb ei        op1       op2       pc        wp wwp
    vecs[0]  = mk(16'h1031, 0, 16'h0100, 1, 3, 16'h1234, 0, 0, 2, 0, 16'h1031, 16'h1234, 16'h0000, 16'h0100, 0, 0);
    vecs[1]  = mk(16'h1302, 0, 16'h0102, 1, 0, 16'h0005, 0, 0, 2, 0, 16'h1302, 16'h0000, 16'h1234, 16'h0102, 0, 0);
    vecs[2]  = mk(16'h1124, 0, 16'h0104, 1, 5, 16'h5555, 0, 0, 2, 0, 16'h1124, 16'h0000, 16'h0000, 16'h0104, 1, 1);
    vecs[3]  = mk(16'h1467, 0, 16'h0106, 1, 4, 16'h4444, 0, 0, 2, 0, 16'h1467, 16'h0000, 16'h4444, 16'h0106, 1, 0);
    vecs[4]  = mk(16'h1948, 0, 16'h0108, 1, 9, 16'h0909, 0, 0, 2, 0, 16'h1948, 16'h4444, 16'h0909, 16'h0108, 0, 1);
    vecs[5]  = mk(16'h9A15, 0, 16'h010A, 0, 0, 16'h0000, 0, 0, 2, 0, 16'h9A15, 16'h0000, 16'h5555, 16'h010A, 0, 0);
    vecs[6]  = mk(16'h1050, 0, 16'h010C, 0, 0, 16'h0000, 0, 0, 2, 0, 16'h1050, 16'h5555, 16'h0000, 16'h010C, 0, 0);
    vecs[7]  = mk(16'h8032, 0, 16'h010E, 0, 0, 16'h0000, 0, 0, 2, 0, 16'h8032, 16'h1234, 16'h0000, 16'h010E, 0, 0);
    vecs[8]  = mk(16'h1326, 0, 16'h0110, 0, 0, 16'h0000, 0, 1, 1, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0);
    vecs[9]  = mk(16'h1FFF, 0, 16'hDEAD, 1, 2, 16'h2222, 0, 0, 2, 0, 16'h1326, 16'h2222, 16'h1234, 16'h0110, 0, 1);
    vecs[10] = mk(16'h1060, 0, 16'h0114, 0, 0, 16'h0000, 0, 0, 2, 0, 16'h1060, 16'h0000, 16'h0000, 16'h0114, 1, 0);
    vecs[11] = mk(16'h8017, 0, 16'h0116, 0, 0, 16'h0000, 0, 0, 2, 0, 16'h8017, 16'h0000, 16'h0000, 16'h0116, 0, 0);
    vecs[12] = mk(16'h1707, 0, 16'h0118, 0, 0, 16'h0000, 1, 1, 1, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0);
    vecs[13] = mk(16'h1727, 0, 16'h0200, 0, 0, 16'h0000, 0, 0, 2, 0, 16'h1727, 16'h2222, 16'h0000, 16'h0200, 0, 0);
    vecs[14] = mk(16'h1777, 1, 16'h0202, 0, 0, 16'h0000, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0);
    vecs[15] = mk(16'hF0C4, 0, 16'h0204, 0, 0, 16'h0000, 0, 0, 2, 0, 16'hF0C4, 16'h0000, 16'h0000, 16'h0204, 0, 0);
    vecs[16] = mk(16'hA043, 0, 16'h0206, 0, 0, 16'h0000, 0, 0, 2, 0, 16'hA043, 16'h4444, 16'h1234, 16'h0206, 0, 0);
    vecs[17] = mk(16'h1033, 0, 16'h0208, 0, 0, 16'h0000, 0, 0, 2, 0, 16'h1033, 16'h1234, 16'h0000, 16'h0208, 0, 0);

    repeat (2) @(negedge clk);
    chk16("reset bubble_out", -1, {15'd0, bubble_out}, 16'd1);
    chk16("reset stall", -1, {15'd0, stall}, 16'd0);
    chk16("reset instr_out", -1, instr_out, 16'h0000);
    chk16("reset op1_out", -1, op1_out, 16'h0000);
    chk16("reset pc_out", -1, pc_out, 16'h0000);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      instr_in = vecs[i].instr; bubble_in = vecs[i].bub; pc_in = vecs[i].pc;
      reg_we = vecs[i].we; reg_tgt = vecs[i].tgt; reg_wdata = vecs[i].wd; flush = vecs[i].fl;
      #1;
      chk16("stall", i, {15'd0, stall}, {15'd0, vecs[i].st});
      e = vecs[i].e;
      e.idx = i;
      sb.push_back(e);
      @(negedge clk);
      pop_compare();
    end

    // Mid-run reset: outputs return to idle and registers read zero afterwards.
    instr_in = 16'h1430; bubble_in = 1'b0; pc_in = 16'h0300; reg_we = 1'b0; flush = 1'b0;
    rst = 1'b1;
    #1;
    chk16("midrst bubble_out", 100, {15'd0, bubble_out}, 16'd1);
    chk16("midrst stall", 100, {15'd0, stall}, 16'd0);
    chk16("midrst op1_out", 100, op1_out, 16'h0000);
    chk16("midrst op2_out", 100, op2_out, 16'h0000);
    chk16("midrst instr_out", 100, instr_out, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    e.idx = 101; e.chk = 2'd2; e.eb = 1'b0; e.ei = 16'h1430; e.e1 = 16'h0000; e.e2 = 16'h0000;
    e.ep = 16'h0300; e.wp = 1'b0; e.wwp = 1'b0;
    sb.push_back(e);
    @(negedge clk);
    pop_compare();

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
